cmd_uart_tx: RTL and testbench
==============================

CMD_UART_TX -- requirements
Module: cmd_uart_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame (5..9).
REQ-002 SHALL have parameter DEPTH, default 4: transmit FIFO entries (power of 2, 2..16).
REQ-003 SHALL have parameter BAUD_DIV, default 2604: clocks per bit (>=2); 2604 gives 19200 baud at 50 MHz.
REQ-004 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1: 1 or 2.
REQ-006 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have port trmt  in  1  push request; tx_data is written when trmt=1 and full=0.
REQ-009 SHALL have port tx_data  in  DATA_W  byte to queue.
REQ-010 SHALL have port TX  out  1  serial line, idle high, registered.
REQ-011 SHALL have port tx_done  out  1  one-clock pulse at the end of each frame.
REQ-012 SHALL have port busy  out  1  high while a frame is in progress.
REQ-013 SHALL have port full  out  1  FIFO holds DEPTH entries.
REQ-014 SHALL have port empty  out  1  FIFO holds 0 entries.
REQ-015 SHALL have port ovfl  out  1  sticky flag: trmt was asserted while full=1.

Function
REQ-016 SHALL queue data in a DEPTH-entry FIFO with wrap-around read/write pointers and an occupancy count of width clog2(DEPTH)+1.
REQ-017 SHALL ignore trmt when full=1, even if a pop occurs on the same cycle, and SHALL set ovfl on that cycle.
REQ-018 SHALL perform a simultaneous push and pop at non-full occupancy with the count unchanged.
REQ-019 SHALL use FSM states IDLE, START, DATA, PAR, STOP.
REQ-020 SHALL transition IDLE->START on any cycle where empty=0, popping the head entry into a shift register on that edge.
REQ-021 SHALL transition START->DATA after BAUD_DIV clocks.
REQ-022 SHALL transition DATA->PAR (PARITY!=0) or DATA->STOP after DATA_W bit periods.
REQ-023 SHALL transition PAR->STOP after one bit period.
REQ-024 SHALL, at the end of STOP_BITS periods, go STOP->START with the next entry popped if empty=0, otherwise STOP->IDLE; no idle bit is inserted between back-to-back frames.
REQ-025 SHALL drive TX low in START, LSB first in DATA, the parity bit in PAR, and high in STOP and IDLE.
REQ-026 SHALL use even parity = XOR of the data bits and odd parity = its inverse.
REQ-027 SHALL implement a baud counter that counts 0..BAUD_DIV-1, reloads to 0 on every bit boundary and on IDLE->START, and holds at 0 in IDLE.
REQ-028 SHALL produce every bit period, start, data, parity and stop, of exactly BAUD_DIV clocks.
REQ-029 SHALL have latency from a trmt edge with empty FIFO and FSM in IDLE to TX falling of exactly 2 clocks: push at edge N, pop and START at edge N+1, TX=0 registered at edge N+2.
REQ-030 SHALL pulse tx_done for exactly one clock on the cycle the final stop period completes.
REQ-031 SHALL assert busy in all states except IDLE.
REQ-032 SHALL not alter the frame in flight when tx_data changes while a frame is being sent.
REQ-033 SHALL, for a frame of F = 1 + DATA_W + (PARITY!=0) + STOP_BITS bits, have back-to-back frames start F*BAUD_DIV clocks apart.

Reset
REQ-034 SHALL, on rst_n=0 at any time including mid-frame: FSM=IDLE, TX=1 immediately (asynchronous), FIFO pointers and count=0, empty=1, full=0, busy=0, tx_done=0, ovfl=0, baud counter=0.
REQ-035 SHALL discard queued data on reset and not resume it after rst_n deasserts.

Verification (BAUD_DIV=4, DATA_W=8 unless stated)
REQ-036 SHALL cover single byte: PARITY=0, STOP_BITS=1, push 0x67 -> TX low 2 clocks later, then data bits 1,1,1,0,0,1,1,0 (4 clocks each), then stop high; tx_done pulse 40 clocks after TX fall; busy=0 after.
REQ-037 SHALL cover parity: PARITY=1, push 0x67 -> parity bit 1, frame 44 clocks; PARITY=2 -> parity bit 0.
REQ-038 SHALL cover burst and overflow: DEPTH=4, push 0x01..0x06 on 6 consecutive cycles -> first popped immediately, 0x02..0x05 queued, full=1, 0x06 dropped, ovfl=1; five frames 40 clocks apart with no idle gap, then empty=1.
REQ-039 SHALL cover two stop bits: STOP_BITS=2, push 0xA5 then 0x3C -> second start bit begins exactly 44 clocks after the first.
REQ-040 SHALL cover reset mid-frame: assert rst_n=0 during data bit 3 with 2 bytes queued -> TX=1 without a clock edge, empty=1, ovfl=0; after release, no further frames and TX stays high.

Source files
------------

// File: rtl/cmd_uart_tx.sv
`default_nettype none
// ============================================================================
// cmd_uart_tx : UART transmitter fed by a small FIFO, configurable framing
// Revision    : 1.0
// ============================================================================
module cmd_uart_tx #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 4,
   parameter int BAUD_DIV  = 2604,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trmt,
   input  logic [DATA_W-1:0] tx_data,
   output logic              TX,
   output logic              tx_done,
   output logic              busy,
   output logic              full,
   output logic              empty,
   output logic              ovfl
);

   localparam int   c_ptr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int   c_cnt_w  = $clog2(DEPTH) + 1;
   localparam int   c_baud_w = $clog2(BAUD_DIV);
   localparam logic c_odd    = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP  = 3'd4
   } state_t;

   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [c_cnt_w-1:0]  r_count;
   logic                r_ovfl;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_baud_w-1:0] r_baud;
   logic [3:0]          r_bit_cnt;
   logic [3:0]          w_bit_cnt_nxt;
   logic [DATA_W-1:0]   r_shift;
   logic                r_par;
   logic                r_tx;
   logic                r_done_pre;
   logic                r_tx_done;

   logic                w_push;
   logic                w_pop;
   logic                w_bit_end;
   logic                w_shift_en;
   logic                w_frame_end;
   logic                w_tx_nxt;

   assign full    = (r_count == c_cnt_w'(DEPTH));
   assign empty   = (r_count == '0);
   assign ovfl    = r_ovfl;
   assign busy    = (r_state != S_IDLE);
   assign TX      = r_tx;
   assign tx_done = r_tx_done;

   // A push while full is dropped even if a pop frees a slot on the same edge.
   assign w_push    = trmt && !full;
   assign w_bit_end = (r_baud == c_baud_w'(BAUD_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovfl   <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
         if (trmt && full) r_ovfl <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= tx_data;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_pop         = 1'b0;
      w_shift_en    = 1'b0;
      w_frame_end   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!empty) begin
               w_state_nxt = S_START;
               w_pop       = 1'b1;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_nxt   = S_DATA;
               w_bit_cnt_nxt = '0;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_shift_en = 1'b1;
               if (r_bit_cnt == 4'(DATA_W - 1)) begin
                  w_bit_cnt_nxt = '0;
                  w_state_nxt   = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end
            end
         end
         S_PAR: begin
            if (w_bit_end) begin
               w_state_nxt   = S_STOP;
               w_bit_cnt_nxt = '0;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (r_bit_cnt == 4'(STOP_BITS - 1)) begin
                  w_frame_end   = 1'b1;
                  w_bit_cnt_nxt = '0;
                  // Chain straight into the next start bit when data is waiting.
                  if (!empty) begin
                     w_state_nxt = S_START;
                     w_pop       = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_tx_nxt = 1'b1;
      case (r_state)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = r_shift[0];
         S_PAR:   w_tx_nxt = r_par;
         default: w_tx_nxt = 1'b1;
      endcase
   end

   // TX and tx_done both trail the state register by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= '0;
         r_baud     <= '0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_tx       <= 1'b1;
         r_done_pre <= 1'b0;
         r_tx_done  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         if (r_state == S_IDLE || w_bit_end) r_baud <= '0;
         else                                r_baud <= r_baud + c_baud_w'(1);
         if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_par   <= (^r_mem[r_rd_ptr]) ^ c_odd;
         end else if (w_shift_en) begin
            r_shift <= r_shift >> 1;
         end
         r_tx       <= w_tx_nxt;
         r_done_pre <= w_frame_end;
         r_tx_done  <= r_done_pre;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cmd_uart_tx.sv
`default_nettype none
// tb_cmd_uart_tx : four framing variants share one random stimulus stream;
// a queue-level reference model feeds a scoreboard that decodes each TX line.
module tb_cmd_uart_tx;

   localparam int c_baud  = 4;
   localparam int c_depth = 4;
   localparam int c_ncfg  = 4;

   function automatic int par_cfg(int i);
      return (i == 3) ? 0 : i;
   endfunction

   function automatic int stop_cfg(int i);
      return (i >= 2) ? 2 : 1;
   endfunction

   function automatic int nbits(int i);
      return 1 + 8 + ((par_cfg(i) != 0) ? 1 : 0) + stop_cfg(i);
   endfunction

   // Bit k of the result is the k-th bit on the line; unused upper bits read as idle.
   function automatic logic [15:0] frame_of(int i, logic [7:0] d);
      logic [15:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
      if (par_cfg(i) == 1) f[9] = ^d;
      if (par_cfg(i) == 2) f[9] = ~^d;
      return f;
   endfunction

   typedef struct {
      logic [15:0] bits;
      int          start;
   } exp_t;

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b0;
   logic              trmt    = 1'b0;
   logic [7:0]        tx_data = 8'h00;
   logic [c_ncfg-1:0] tx_w, done_w, busy_w, full_w, empty_w, ovfl_w;

   always #5 clk = ~clk;

   for (genvar g = 0; g < c_ncfg; g++) begin : g_cfg
      cmd_uart_tx #(
         .DATA_W   (8),
         .DEPTH    (c_depth),
         .BAUD_DIV (c_baud),
         .PARITY   (par_cfg(g)),
         .STOP_BITS(stop_cfg(g))
      ) u_dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .trmt   (trmt),
         .tx_data(tx_data),
         .TX     (tx_w[g]),
         .tx_done(done_w[g]),
         .busy   (busy_w[g]),
         .full   (full_w[g]),
         .empty  (empty_w[g]),
         .ovfl   (ovfl_w[g])
      );
   end

   // Reference model: queue of pending bytes plus clocks left in the current frame.
   exp_t       sbq    [c_ncfg][$];
   logic [7:0] pend   [c_ncfg][$];
   int         remain [c_ncfg];
   bit         ovfl_m [c_ncfg];
   int         cyc = 0;
   int         m_sz;
   logic [7:0] m_d;
   exp_t       m_e;

   initial begin
      for (int i = 0; i < c_ncfg; i++) begin
         remain[i] = 0;
         ovfl_m[i] = 1'b0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < c_ncfg; i++) begin
               pend[i].delete();
               sbq[i].delete();
               remain[i] = 0;
               ovfl_m[i] = 1'b0;
            end
         end else begin
            cyc++;
            for (int i = 0; i < c_ncfg; i++) begin
               m_sz = pend[i].size();
               if (remain[i] > 0) remain[i]--;
               if (m_sz > 0 && remain[i] == 0) begin
                  m_d       = pend[i].pop_front();
                  m_e.bits  = frame_of(i, m_d);
                  m_e.start = cyc + 1;
                  sbq[i].push_back(m_e);
                  remain[i] = nbits(i) * c_baud;
               end
               if (trmt) begin
                  if (m_sz == c_depth) ovfl_m[i] = 1'b1;
                  else                 pend[i].push_back(tx_data);
               end
            end
         end
      end
   end

   // Scoreboard / monitor
   int          n_cmp   = 0;
   int          n_bad   = 0;
   bit          end_req = 1'b0;
   bit          rst_seen = 1'b0;
   int          rx_t     [c_ncfg];
   logic [15:0] act      [c_ncfg];
   bit          glitch   [c_ncfg];
   int          start_c  [c_ncfg];
   int          done_due [c_ncfg];

   task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s dut%0d cyc %0d: got %0h want %0h", nm, i, cyc, got, want);
      end
   endtask

   task automatic mon_one(int i);
      exp_t e;
      logic want_done;
      int   k;
      chk("flags", i, 32'({busy_w[i], empty_w[i], full_w[i], ovfl_w[i]}),
          32'({remain[i] > 0, pend[i].size() == 0, pend[i].size() == c_depth, ovfl_m[i]}));
      want_done = (done_due[i] == cyc);
      if (done_w[i] || want_done) chk("tx_done", i, 32'(done_w[i]), 32'(want_done));
      if (rx_t[i] < 0) begin
         if (tx_w[i] == 1'b0) begin
            rx_t[i]    = 0;
            act[i]     = '1;
            act[i][0]  = 1'b0;
            glitch[i]  = 1'b0;
            start_c[i] = cyc;
         end
      end else begin
         rx_t[i]++;
         k = rx_t[i] / c_baud;
         if (rx_t[i] % c_baud == 0) act[i][k] = tx_w[i];
         else if (tx_w[i] != act[i][k]) glitch[i] = 1'b1;
         if (rx_t[i] == nbits(i) * c_baud - 1) begin
            rx_t[i] = -1;
            if (sbq[i].size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL frame_unexpected dut%0d cyc %0d: got frame %0h want none", i, cyc, act[i]);
            end else begin
               e = sbq[i].pop_front();
               chk("frame_bits", i, 32'({glitch[i], act[i]}), 32'({1'b0, e.bits}));
               chk("frame_start", i, start_c[i], e.start);
               done_due[i] = e.start + nbits(i) * c_baud;
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < c_ncfg; i++) begin
         rx_t[i]     = -1;
         done_due[i] = -1;
         act[i]      = '1;
         glitch[i]   = 1'b0;
         start_c[i]  = 0;
      end
      while (!end_req) begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            if (!rst_seen) begin
               #1;
               for (int i = 0; i < c_ncfg; i++)
                  chk("reset_out", i,
                      32'({tx_w[i], done_w[i], busy_w[i], full_w[i], empty_w[i], ovfl_w[i]}),
                      32'(6'b100010));
               rst_seen = 1'b1;
            end
            for (int i = 0; i < c_ncfg; i++) begin
               rx_t[i]     = -1;
               done_due[i] = -1;
            end
         end else begin
            rst_seen = 1'b0;
            for (int i = 0; i < c_ncfg; i++) mon_one(i);
         end
      end
      for (int i = 0; i < c_ncfg; i++) chk("frames_left", i, sbq[i].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Stimulus
   task automatic push(logic [7:0] d);
      @(negedge clk);
      trmt    = 1'b1;
      tx_data = d;
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         trmt    = 1'b0;
         tx_data = 8'($urandom);
      end
   endtask

   function automatic bit all_idle();
      for (int i = 0; i < c_ncfg; i++)
         if (remain[i] != 0 || pend[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain();
      for (int n = 0; n < 3000; n++) begin
         if (all_idle()) break;
         idle(1);
      end
      idle(4);
   endtask

   initial begin
      idle(3);
      rst_n = 1'b1;
      idle(2);
      push(8'h67);
      idle(60);
      for (int d = 1; d <= 6; d++) push(8'(d));
      drain();
      push(8'hA5);
      push(8'h3C);
      drain();
      repeat (300) begin
         if ($urandom_range(0, 3) == 0) push(8'($urandom));
         else                           idle(1);
      end
      repeat (4) begin
         repeat ($urandom_range(3, 8)) push(8'($urandom));
         idle($urandom_range(0, 60));
      end
      drain();
      push(8'h5A);
      push(8'hC3);
      push(8'h96);
      idle(18);
      @(negedge clk);
      #2 rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(100);
      end_req = 1'b1;
   end

endmodule
`default_nettype wire
